// File: rtl/regfile_scoreboard.sv
// Register file with one-hot write decode, two combinational read ports with optional write-through
// bypass, and a per-register pending-write scoreboard; writes/claims land in 1 edge, no backpressure.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic              ctrl_claimEnable,
  input  logic [ADDR_W-1:0] ctrl_claimReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic              busy_readRegA,
  output logic              busy_readRegB,
  output logic [(1<<ADDR_W)-1:0] busy_vector
);

  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [N];
  logic [N-1:0]      busy_q, busy_d;
  logic [N-1:0]      wr_sel, clm_sel;
  logic              wr_ok;
  logic              hit_a, hit_b;

  assign wr_ok = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));

  always_comb begin
    wr_sel  = '0;
    clm_sel = '0;
    if (ctrl_writeEnable) wr_sel[ctrl_writeReg] = 1'b1;
    if (ctrl_claimEnable) clm_sel[ctrl_claimReg] = 1'b1;
    if (ZERO_REG != 0) begin
      wr_sel[0]  = 1'b0;
      clm_sel[0] = 1'b0;
    end
    // A claim in the same cycle as the write means a newer producer is in flight.
    busy_d = (busy_q & ~wr_sel) | clm_sel;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_sel[i]) regs_q[i] <= data_writeReg;
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vector = busy_q;

  always_comb begin
    hit_a = (BYPASS != 0) && wr_ok && (ctrl_writeReg == ctrl_readRegA);
    hit_b = (BYPASS != 0) && wr_ok && (ctrl_writeReg == ctrl_readRegB);

    data_readRegA = regs_q[ctrl_readRegA];
    busy_readRegA = busy_q[ctrl_readRegA];
    if ((ZERO_REG != 0) && (ctrl_readRegA == '0)) data_readRegA = '0;
    if (hit_a) begin
      data_readRegA = data_writeReg;
      busy_readRegA = 1'b0;
    end

    data_readRegB = regs_q[ctrl_readRegB];
    busy_readRegB = busy_q[ctrl_readRegB];
    if ((ZERO_REG != 0) && (ctrl_readRegB == '0)) data_readRegB = '0;
    if (hit_b) begin
      data_readRegB = data_writeReg;
      busy_readRegB = 1'b0;
    end
  end

endmodule
